// File: rtl/serial_rom_pkg.sv
// Shared types and sizing helpers for the serial ROM reader slice.
package serial_rom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_WORD_W = 4;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_rom_deser.sv
// Serial-to-parallel word assembler: shift register, bit counter and output word register.
// Bit order is LSB-first by default; define SERIAL_ROM_MSB_FIRST_EN for MSB-first wire order.
module serial_rom_deser
  import serial_rom_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              load,
  input  logic              din,
  output logic              last,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned BW = cnt_w(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_nxt;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;

  assign last = (bit_cnt_q == BW'(WORD_W - 1));
  assign word = word_q;

  always_comb begin
`ifdef SERIAL_ROM_MSB_FIRST_EN
    word_nxt    = sr_q << 1;
    word_nxt[0] = din;
`else
    word_nxt           = sr_q >> 1;
    word_nxt[WORD_W-1] = din;
`endif
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    if (clr) begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      sr_d      = word_nxt;
      bit_cnt_d = last ? '0 : bit_cnt_q + BW'(1);
    end
    // The final sample goes straight into the output word in the same edge.
    if (load) begin
      word_d = word_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
    end
  end

endmodule

// File: rtl/serial_rom_reader.sv
// Request/response front end for the serial-output ROM: drives select, deserialises one word.
// Bit order is selected by SERIAL_ROM_MSB_FIRST_EN inside serial_rom_deser.
module serial_rom_reader
  import serial_rom_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned WORD_W  = DEF_WORD_W,
  parameter int unsigned LAT     = 1,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_start,
  input  logic              mem_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned CW = cnt_w((LAT > GAP_CYC) ? LAT : GAP_CYC);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_cs_q, mem_cs_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              deser_clr, deser_shift, deser_load, deser_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_cs_d    = mem_cs_q;
    rsp_valid_d = rsp_valid_q;
    deser_clr   = 1'b0;
    deser_shift = 1'b0;
    deser_load  = 1'b0;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_addr_d = req_addr;
          mem_cs_d   = 1'b1;
          cnt_d      = '0;
          deser_clr  = 1'b1;
          state_d    = SEL;
        end
      end
      SEL: begin
        if (cnt_q == CW'(LAT - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        deser_shift = 1'b1;
        if (deser_last) begin
          deser_load  = 1'b1;
          mem_cs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: the cycle that consumes a response cannot also accept.
    req_ready_d = (state_d == IDLE) && !rsp_valid_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_cs_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_cs_q    <= mem_cs_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  serial_rom_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (deser_clr),
    .shift_en (deser_shift),
    .load     (deser_load),
    .din      (mem_data),
    .last     (deser_last),
    .word     (rsp_data)
  );

  assign req_ready = req_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_cs    = mem_cs_q;
  assign mem_start = mem_cs_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule
